// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared y86 constants and fetch state encoding
// Purpose: icode constants, the "no register" code and the fetch FSM state
//          type shared by the fetch, decode and PC-update stages.
// Ports:   none (package).
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// rtl/pc_fetch_sequencer_if.sv - byte-wide instruction memory req/ack bus
// Purpose: groups the instruction-memory handshake between the fetch
//          sequencer (master) and the instruction memory (slave).
// Signals: mem_req/mem_addr (master->slave), mem_ack/mem_rdata/mem_err
//          (slave->master); mem_err is only meaningful with mem_ack.
interface pc_fetch_sequencer_if;

  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        mem_err;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata,
    input  mem_err
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata,
    output mem_err
  );

endinterface

// File: rtl/y86_instr_len.sv
// rtl/y86_instr_len.sv - combinational y86 instruction length decoder
// Purpose: maps an icode to its byte length and which optional parts
//          (register byte, 8-byte constant) it carries.
// Ports:   icode in 4; length out 4; need_regids, need_valc, legal out 1.
//          Illegal icodes (12-15) report length 1 with legal=0.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic [3:0] length,
  output logic       need_regids,
  output logic       need_valc,
  output logic       legal
);

  always_comb begin
    length      = 4'd1;
    need_regids = 1'b0;
    need_valc   = 1'b0;
    legal       = 1'b1;
    case (icode)
      IHALT, INOP, IRET: length = 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: begin
        length      = 4'd2;
        need_regids = 1'b1;
      end
      IJXX, ICALL: begin
        length    = 4'd9;
        need_valc = 1'b1;
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        length      = 4'd10;
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - y86 PC register and byte-serial instruction fetch
// Purpose: holds the architectural PC, fetches one instruction a byte at a
//          time, decodes its fields and presents them until pc_load.
// Ports:   clk, rst (async, active high); updated_pc/pc_load from the
//          PC-update stage; imem (memory master port); pc, icode, ifun,
//          rA, rB, valC, valP, fetch_valid, instr_valid, halt, imem_error.
module pc_fetch_sequencer
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [63:0]                 updated_pc,
  input  logic                        pc_load,
  pc_fetch_sequencer_if.master        imem,
  output logic [63:0]                 pc,
  output logic [3:0]                  icode,
  output logic [3:0]                  ifun,
  output logic [3:0]                  rA,
  output logic [3:0]                  rB,
  output logic [63:0]                 valC,
  output logic [63:0]                 valP,
  output logic                        fetch_valid,
  output logic                        instr_valid,
  output logic                        halt,
  output logic                        imem_error
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [3:0]   idx_q, idx_d;
  logic [3:0]   icode_q, icode_d;
  logic [3:0]   ifun_q, ifun_d;
  logic [3:0]   ra_q, ra_d;
  logic [3:0]   rb_q, rb_d;
  logic [63:0]  valc_q, valc_d;
  logic [63:0]  valp_q, valp_d;
  logic         instr_valid_q, instr_valid_d;
  logic         imem_error_q, imem_error_d;

  // On byte 0 the icode is not registered yet, so decode it straight from
  // the returned byte; afterwards use the captured icode.
  logic [3:0] icode_sel;
  logic [3:0] len_cur;
  logic       need_reg_cur;
  logic       need_valc_cur;
  logic       legal_cur;
  logic       is_last;
  logic [3:0] valc_off;
  logic [2:0] valc_pos;

  assign icode_sel = (idx_q == 4'd0) ? imem.mem_rdata[7:4] : icode_q;

  y86_instr_len u_len (
    .icode       (icode_sel),
    .length      (len_cur),
    .need_regids (need_reg_cur),
    .need_valc   (need_valc_cur),
    .legal       (legal_cur)
  );

  assign is_last  = (idx_q == (len_cur - 4'd1));
  // valC starts right after the opcode byte, or after the register byte.
  assign valc_off = idx_q - (need_reg_cur ? 4'd2 : 4'd1);
  assign valc_pos = valc_off[2:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    idx_d         = idx_q;
    icode_d       = icode_q;
    ifun_d        = ifun_q;
    ra_d          = ra_q;
    rb_d          = rb_q;
    valc_d        = valc_q;
    valp_d        = valp_q;
    instr_valid_d = instr_valid_q;
    imem_error_d  = imem_error_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem.mem_ack) begin
          if (imem.mem_err) begin
            imem_error_d = 1'b1;
            state_d      = ST_HALT;
          end else begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd0) begin
              icode_d       = imem.mem_rdata[7:4];
              ifun_d        = imem.mem_rdata[3:0];
              instr_valid_d = legal_cur;
              valp_d        = pc_q + {60'd0, len_cur};
              if (!need_reg_cur) begin
                ra_d = RNONE;
                rb_d = RNONE;
              end
            end else if (idx_q == 4'd1 && need_reg_cur) begin
              ra_d = imem.mem_rdata[7:4];
              rb_d = imem.mem_rdata[3:0];
            end else if (need_valc_cur) begin
              valc_d[{valc_pos, 3'b000} +: 8] = imem.mem_rdata;
            end
            if (is_last) begin
              state_d = (icode_sel == IHALT || !legal_cur) ? ST_HALT : ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (pc_load) begin
          pc_d          = updated_pc;
          idx_d         = 4'd0;
          icode_d       = 4'd0;
          ifun_d        = 4'd0;
          ra_d          = 4'd0;
          rb_d          = 4'd0;
          valc_d        = 64'd0;
          valp_d        = 64'd0;
          instr_valid_d = 1'b0;
          state_d       = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      idx_q         <= 4'd0;
      icode_q       <= 4'd0;
      ifun_q        <= 4'd0;
      ra_q          <= 4'd0;
      rb_q          <= 4'd0;
      valc_q        <= 64'd0;
      valp_q        <= 64'd0;
      instr_valid_q <= 1'b0;
      imem_error_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      idx_q         <= idx_d;
      icode_q       <= icode_d;
      ifun_q        <= ifun_d;
      ra_q          <= ra_d;
      rb_q          <= rb_d;
      valc_q        <= valc_d;
      valp_q        <= valp_d;
      instr_valid_q <= instr_valid_d;
      imem_error_q  <= imem_error_d;
    end
  end

  // Request is a pure function of state so reset removes it immediately.
  assign imem.mem_req  = (state_q == ST_FETCH);
  assign imem.mem_addr = pc_q + {60'd0, idx_q};

  assign pc          = pc_q;
  assign icode       = icode_q;
  assign ifun        = ifun_q;
  assign rA          = ra_q;
  assign rB          = rb_q;
  assign valC        = valc_q;
  assign valP        = valp_q;
  assign fetch_valid = (state_q == ST_DONE) || (state_q == ST_HALT);
  assign instr_valid = instr_valid_q;
  assign halt        = (state_q == ST_HALT);
  assign imem_error  = imem_error_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [63:0] updated_pc;
  logic        pc_load;
  logic [63:0] pc;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic        fetch_valid, instr_valid, halt, imem_error;

  pc_fetch_sequencer_if imem_if ();

  pc_fetch_sequencer #(.RESET_PC(64'd0)) dut (
    .clk         (clk),
    .rst         (rst),
    .updated_pc  (updated_pc),
    .pc_load     (pc_load),
    .imem        (imem_if),
    .pc          (pc),
    .icode       (icode),
    .ifun        (ifun),
    .rA          (rA),
    .rB          (rB),
    .valC        (valC),
    .valP        (valP),
    .fetch_valid (fetch_valid),
    .instr_valid (instr_valid),
    .halt        (halt),
    .imem_error  (imem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit [7:0] mem [bit [63:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    int          len;
    logic        valid, halt;
  } exp_t;

  // Instruction lengths straight from the ISA table, indexed by icode.
  function automatic exp_t model(input logic [63:0] ipc, input bit [7:0] b[10]);
    exp_t e;
    int len_tab[16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
    e.icode = b[0][7:4];
    e.ifun  = b[0][3:0];
    e.len   = len_tab[e.icode];
    e.valid = (e.icode <= 4'd11);
    e.halt  = (e.icode == 4'd0) || !e.valid;
    if (e.valid && (e.len == 2 || e.len == 10)) begin
      e.ra = b[1][7:4];
      e.rb = b[1][3:0];
    end else begin
      e.ra = 4'hF;
      e.rb = 4'hF;
    end
    e.valc = 64'd0;
    if (e.len >= 9)
      for (int k = 0; k < 8; k++) e.valc = e.valc | (64'(b[e.len - 8 + k]) << (8 * k));
    e.valp = ipc + 64'(e.len);
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    pc_load = 1'b0;
    imem_if.mem_ack = 1'b0;
    imem_if.mem_err = 1'b0;
    imem_if.mem_rdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Serves memory byte by byte (wmode<0: random 0..2 wait states per byte)
  // until fetch_valid, then checks the decoded outputs against the model.
  task automatic run_instr(input logic [63:0] ipc, input bit [7:0] b[10], input int wmode,
                           input bit err_en, input int err_idx, input int exp_cycles);
    exp_t e;
    int cycles = 0, acks = 0, w = 0, target;
    for (int i = 0; i < 10; i++) mem[ipc + 64'(i)] = b[i];
    e = model(ipc, b);
    target = (wmode >= 0) ? wmode : int'($urandom_range(0, 2));
    forever begin
      if (fetch_valid) break;
      if (cycles > 500) begin
        chk("fetch_timeout", 64'(cycles), 64'd0);
        break;
      end
      if (imem_if.mem_req) begin
        cycles++;
        if (w >= target) begin
          chk("mem_addr", imem_if.mem_addr, ipc + 64'(acks));
          imem_if.mem_ack   = 1'b1;
          imem_if.mem_rdata = mem[imem_if.mem_addr];
          imem_if.mem_err   = err_en && (acks == err_idx);
          acks++;
          w = 0;
          target = (wmode >= 0) ? wmode : int'($urandom_range(0, 2));
        end else begin
          imem_if.mem_ack = 1'b0;
          imem_if.mem_err = 1'b0;
          w++;
        end
      end else begin
        imem_if.mem_ack = 1'b0;
        imem_if.mem_err = 1'b0;
      end
      @(negedge clk);
    end
    imem_if.mem_ack = 1'b0;
    imem_if.mem_err = 1'b0;
    if (!err_en) begin
      chk("icode", icode, e.icode);
      chk("ifun", ifun, e.ifun);
      chk("rA", rA, e.ra);
      chk("rB", rB, e.rb);
      chk("valC", valC, e.valc);
      chk("valP", valP, e.valp);
      chk("instr_valid", instr_valid, e.valid);
      chk("halt", halt, e.halt);
      chk("imem_error", imem_error, 1'b0);
      chk("pc", pc, ipc);
      chk("ack_count", 64'(acks), 64'(e.len));
      if (exp_cycles >= 0) chk("fetch_cycles", 64'(cycles), 64'(exp_cycles));
    end
  endtask

  task automatic pulse_load(input logic [63:0] npc);
    updated_pc = npc;
    pc_load = 1'b1;
    @(negedge clk);
    pc_load = 1'b0;
    chk("load_req", imem_if.mem_req, 1'b1);
    chk("load_addr", imem_if.mem_addr, npc);
    chk("load_icode_clr", icode, 4'd0);
  endtask

  task automatic check_stuck(input logic [63:0] held_pc);
    for (int i = 0; i < 3; i++) begin
      updated_pc = 64'h1234 + 64'(i);
      pc_load = 1'b1;
      @(negedge clk);
      pc_load = 1'b0;
      @(negedge clk);
      chk("halt_no_req", imem_if.mem_req, 1'b0);
      chk("halt_held", halt, 1'b1);
    end
    chk("halt_pc_held", pc, held_pc);
  endtask

  initial begin
    bit [7:0] b[10];
    logic [63:0] npc;
    rst = 1'b1;
    pc_load = 1'b0;
    updated_pc = 64'd0;
    imem_if.mem_ack = 1'b0;
    imem_if.mem_err = 1'b0;
    imem_if.mem_rdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", imem_if.mem_req, 1'b0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_fetch_valid", fetch_valid, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_imem_error", imem_error, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_fields", {icode, ifun, rA, rB}, 16'd0);
    chk("rst_valC", valC, 64'd0);
    chk("rst_valP", valP, 64'd0);
    rst = 1'b0;

    // nop at 0, zero-wait
    b = '{8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_instr(64'd0, b, 0, 1'b0, 0, 1);
    pulse_load(64'h100);

    // irmovq at 0x100
    b = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    run_instr(64'h100, b, 0, 1'b0, 0, 10);
    chk("irmovq_valC", valC, 64'h0102030405060708);
    chk("irmovq_valP", valP, 64'h10A);
    pulse_load(64'h20);

    // call at 0x20, one wait per byte
    b = '{8'h80, 8'h40, 0, 0, 0, 0, 0, 0, 0, 0};
    run_instr(64'h20, b, 1, 1'b0, 0, 18);
    chk("call_valP", valP, 64'h29);
    pulse_load(64'h40);

    // random legal instructions with random wait states and PCs
    npc = 64'h40;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 10; i++) b[i] = 8'($urandom);
      b[0][7:4] = 4'($urandom_range(1, 11));
      run_instr(npc, b, -1, 1'b0, 0, -1);
      if (t % 4 == 3) npc = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
      else npc = {$urandom, $urandom};
      pulse_load(npc);
    end

    // wrap-around OPq at all-ones
    run_instr(npc, '{8'h60, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0, 0, -1);
    pulse_load(64'hFFFF_FFFF_FFFF_FFFF);
    b = '{8'h60, 8'h12, 0, 0, 0, 0, 0, 0, 0, 0};
    run_instr(64'hFFFF_FFFF_FFFF_FFFF, b, 0, 1'b0, 0, 2);
    chk("wrap_valP", valP, 64'd1);
    chk("wrap_rA", rA, 4'h1);

    // reset mid-fetch
    pulse_load(64'hFFFF_FFFF_FFFF_FFFF);
    imem_if.mem_ack = 1'b1;
    imem_if.mem_rdata = 8'h60;
    @(negedge clk);
    chk("mid_addr", imem_if.mem_addr, 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req", imem_if.mem_req, 1'b0);
    chk("rst_async_pc", pc, 64'd0);
    imem_if.mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_pc", pc, 64'd0);
    chk("post_rst_req", imem_if.mem_req, 1'b1);
    chk("post_rst_addr", imem_if.mem_addr, 64'd0);
    chk("post_rst_valid", fetch_valid, 1'b0);

    // halt instruction
    do_reset();
    b = '{8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_instr(64'd0, b, 0, 1'b0, 0, 1);
    chk("halt_fetch_valid", fetch_valid, 1'b1);
    check_stuck(64'd0);

    // illegal icode
    do_reset();
    run_instr(64'd0, '{8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0, 0, 1);
    pulse_load(64'h50);
    b = '{8'hC0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_instr(64'h50, b, 0, 1'b0, 0, 1);
    check_stuck(64'h50);

    // memory error on byte index 3 of irmovq
    do_reset();
    run_instr(64'd0, '{8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 1'b0, 0, 1);
    pulse_load(64'h200);
    b = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    run_instr(64'h200, b, 0, 1'b1, 3, -1);
    chk("err_imem_error", imem_error, 1'b1);
    chk("err_halt", halt, 1'b1);
    chk("err_fetch_valid", fetch_valid, 1'b1);
    chk("err_instr_valid", instr_valid, 1'b1);
    chk("err_icode", icode, 4'h3);
    chk("err_regs", {rA, rB}, 8'hF3);
    chk("err_valC", valC, 64'h08);
    check_stuck(64'h200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
